pll_lock_supervisor: RTL and testbench

//  Controller side of the PLL rst/locked interface in the VGA clocking path.
//  - Drives the PLL reset and watches its asynchronous locked output.
//  - Qualifies lock stability and releases a reset for the pixel-path logic
//    (timing generator, framebuffer reader).
//  - Retries the PLL on lock timeout and counts lock-loss events for debug.
//  - Runs on the 50 MHz reference clock.

---
 rtl/pll_lock_supervisor.sv | 150 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier for the VGA pixel clock domain.
// Drives the PLL reset, qualifies a stable lock, and releases the pixel-path reset.
module pll_lock_supervisor #(
   parameter int SYNC_STAGES         = 2,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W               = 8
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             locked,
   input  logic             soft_reset_req,
   output logic             pll_rst,
   output logic             sys_rst,
   output logic             ready,
   output logic [CNT_W-1:0] loss_count,
   output logic [CNT_W-1:0] retry_count
);

   localparam int TIMER_MAX_A = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ?
                                LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
   localparam int TIMER_MAX   = (TIMER_MAX_A > PLL_RST_CYCLES) ? TIMER_MAX_A : PLL_RST_CYCLES;
   localparam int TIMER_W     = $clog2(TIMER_MAX + 1);

   localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(PLL_RST_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_PLL_RESET = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABILIZE = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   locked_s;
   state_t                 state_r;
   state_t                 state_s;
   logic [TIMER_W-1:0]     timer_r;
   logic [TIMER_W-1:0]     timer_s;
   logic [CNT_W-1:0]       loss_s;
   logic [CNT_W-1:0]       retry_s;

   // Saturating increment: debug counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (&value) begin
         result = value;
      end else begin
         result = value + CNT_W'(1);
      end
      return result;
   endfunction

   assign locked_s = sync_r[SYNC_STAGES-1];

   // Synchronizer for the PLL locked flag, which is asynchronous to refclk.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], locked};
      end
   end

   // Next-state, shared timer and debug-counter update.
   always_comb begin
      state_s = state_r;
      timer_s = timer_r + TIMER_W'(1);
      loss_s  = loss_count;
      retry_s = retry_count;
      if (soft_reset_req) begin
         state_s = ST_PLL_RESET;
         timer_s = '0;
      end else begin
         case (state_r)
            ST_PLL_RESET: begin
               if (timer_r == RST_LAST) begin
                  state_s = ST_WAIT_LOCK;
                  timer_s = '0;
               end else begin
                  state_s = ST_PLL_RESET;
               end
            end
            ST_WAIT_LOCK: begin
               // A lock arriving on the timeout cycle wins over the retry.
               if (locked_s) begin
                  state_s = ST_STABILIZE;
                  timer_s = '0;
               end else if (timer_r == TIMEOUT_LAST) begin
                  state_s = ST_PLL_RESET;
                  timer_s = '0;
                  retry_s = sat_inc(retry_count);
               end else begin
                  state_s = ST_WAIT_LOCK;
               end
            end
            ST_STABILIZE: begin
               if (!locked_s) begin
                  state_s = ST_WAIT_LOCK;
                  timer_s = '0;
               end else if (timer_r == STABLE_LAST) begin
                  state_s = ST_RUN;
                  timer_s = '0;
               end else begin
                  state_s = ST_STABILIZE;
               end
            end
            ST_RUN: begin
               if (!locked_s) begin
                  state_s = ST_WAIT_LOCK;
                  timer_s = '0;
                  loss_s  = sat_inc(loss_count);
               end else begin
                  state_s = ST_RUN;
                  timer_s = timer_r;
               end
            end
            default: begin
               state_s = ST_PLL_RESET;
               timer_s = '0;
            end
         endcase
      end
   end

   // State, timer and outputs, all registered from the next state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_PLL_RESET;
         timer_r     <= '0;
         pll_rst     <= 1'b1;
         sys_rst     <= 1'b1;
         ready       <= 1'b0;
         loss_count  <= '0;
         retry_count <= '0;
      end else begin
         state_r     <= state_s;
         timer_r     <= timer_s;
         pll_rst     <= (state_s == ST_PLL_RESET);
         sys_rst     <= (state_s != ST_RUN);
         ready       <= (state_s == ST_RUN);
         loss_count  <= loss_s;
         retry_count <= retry_s;
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a phase/elapsed-cycle reference model
// predicts every output per edge; a monitor pops and compares after each edge.
module tb_pll_lock_supervisor;

   localparam int SYNC   = 2;
   localparam int STABLE = 8;
   localparam int RSTC   = 4;
   localparam int TMO    = 32;
   localparam int CW     = 2;
   localparam int CMAX   = (1 << CW) - 1;

   localparam int PH_HOLD   = 0;
   localparam int PH_ACQ    = 1;
   localparam int PH_SETTLE = 2;
   localparam int PH_LIVE   = 3;

   logic          refclk = 1'b0;
   logic          rst = 1'b0;
   logic          locked = 1'b0;
   logic          soft_reset_req = 1'b0;
   logic          pll_rst;
   logic          sys_rst;
   logic          ready;
   logic [CW-1:0] loss_count;
   logic [CW-1:0] retry_count;

   typedef struct packed {
      logic          pll;
      logic          sys;
      logic          rdy;
      logic [CW-1:0] loss;
      logic [CW-1:0] retry;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   int   m_phase;
   int   m_elapsed;
   int   m_loss;
   int   m_retry;
   bit   m_sync[$];

   pll_lock_supervisor #(
      .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(STABLE), .PLL_RST_CYCLES(RSTC),
      .LOCK_TIMEOUT_CYCLES(TMO), .CNT_W(CW)
   ) dut (
      .refclk(refclk), .rst(rst), .locked(locked), .soft_reset_req(soft_reset_req),
      .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready),
      .loss_count(loss_count), .retry_count(retry_count)
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_sync.delete();
      for (int i = 0; i < SYNC; i++) m_sync.push_back(1'b0);
      m_phase = PH_HOLD;
      m_elapsed = 0;
      m_loss = 0;
      m_retry = 0;
   endtask

   // One refclk edge of the reference behaviour, given the inputs seen at that edge.
   task automatic model_edge(input bit r, input bit l, input bit s);
      bit ls;
      if (r) begin
         model_reset();
         return;
      end
      ls = m_sync[SYNC-1];
      m_sync = {l, m_sync[0:SYNC-2]};
      if (s) begin
         m_phase = PH_HOLD;
         m_elapsed = 0;
      end else begin
         case (m_phase)
            PH_HOLD: begin
               m_elapsed++;
               if (m_elapsed == RSTC) begin m_phase = PH_ACQ; m_elapsed = 0; end
            end
            PH_ACQ: begin
               if (ls) begin
                  m_phase = PH_SETTLE; m_elapsed = 0;
               end else begin
                  m_elapsed++;
                  if (m_elapsed == TMO) begin
                     m_phase = PH_HOLD; m_elapsed = 0;
                     m_retry = (m_retry < CMAX) ? m_retry + 1 : CMAX;
                  end
               end
            end
            PH_SETTLE: begin
               if (!ls) begin
                  m_phase = PH_ACQ; m_elapsed = 0;
               end else begin
                  m_elapsed++;
                  if (m_elapsed == STABLE) begin m_phase = PH_LIVE; m_elapsed = 0; end
               end
            end
            default: begin
               if (!ls) begin
                  m_phase = PH_ACQ; m_elapsed = 0;
                  m_loss = (m_loss < CMAX) ? m_loss + 1 : CMAX;
               end
            end
         endcase
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.pll   = (m_phase == PH_HOLD);
      e.sys   = (m_phase != PH_LIVE);
      e.rdy   = (m_phase == PH_LIVE);
      e.loss  = CW'(m_loss);
      e.retry = CW'(m_retry);
      return e;
   endfunction

   task automatic step(input bit r, input bit l, input bit s);
      @(negedge refclk);
      rst = r;
      locked = l;
      soft_reset_req = s;
      model_edge(r, l, s);
      exp_q.push_back(model_out());
      @(posedge refclk);
      #1;
   endtask

   task automatic run_until_ready(input string name, output int edges);
      edges = 0;
      for (int n = 1; n <= 40; n++) begin
         step(1'b0, 1'b1, 1'b0);
         if (ready) begin
            edges = n;
            break;
         end
      end
      if (edges == 0) chk({name, "_timeout"}, 0, 1);
   endtask

   // Scoreboard monitor: compares every predicted edge against the DUT.
   always @(posedge refclk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("mon_pll_rst", int'(pll_rst), int'(mon_e.pll));
         chk("mon_sys_rst", int'(sys_rst), int'(mon_e.sys));
         chk("mon_ready", int'(ready), int'(mon_e.rdy));
         chk("mon_loss_count", int'(loss_count), int'(mon_e.loss));
         chk("mon_retry_count", int'(retry_count), int'(mon_e.retry));
      end
   end

   initial begin
      int n_edges;
      int pll_fall;
      int sys_edge;
      int rises[$];
      int fall_after;
      bit prev_pll;
      int loss_exp[5];
      int steps;
      int len;
      bit lv;

      model_reset();
      #1 rst = 1'b1;
      #2;
      chk("reset_pll_rst", int'(pll_rst), 1);
      chk("reset_sys_rst", int'(sys_rst), 1);
      chk("reset_ready", int'(ready), 0);
      chk("reset_counts", int'(loss_count) + int'(retry_count), 0);

      // Release with locked already high.
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      pll_fall = 0;
      n_edges = 0;
      for (int n = 1; n <= 40; n++) begin
         step(1'b0, 1'b1, 1'b0);
         if (!pll_rst && pll_fall == 0) pll_fall = n;
         if (ready) begin n_edges = n; break; end
      end
      chk("t1_pll_fall_edge", pll_fall, 4);
      chk("t1_ready_edge", n_edges, 13);
      chk("t1_counts", int'(loss_count) + int'(retry_count), 0);

      // One-cycle glitch while stabilizing is not a loss.
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      run_until_ready("t2", n_edges);
      chk("t2_ready_after_recover", n_edges, 11);
      chk("t2_loss_count", int'(loss_count), 0);

      // Loss in RUN.
      step(1'b1, 1'b1, 1'b0);
      run_until_ready("t3_pre", n_edges);
      sys_edge = 0;
      for (int n = 1; n <= 3; n++) begin
         step(1'b0, 1'b0, 1'b0);
         if (sys_rst && sys_edge == 0) sys_edge = n;
      end
      chk("t3_sys_rst_edge", sys_edge, 3);
      chk("t3_loss_count", int'(loss_count), 1);
      run_until_ready("t3", n_edges);
      chk("t3_ready_after_recover", n_edges, 11);

      // Lock never arrives: periodic retries, saturating retry counter.
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      prev_pll = 1'b1;
      fall_after = 0;
      for (int n = 1; n <= 150; n++) begin
         step(1'b0, 1'b0, 1'b0);
         if (pll_rst && !prev_pll) rises.push_back(n);
         if (!pll_rst && prev_pll && rises.size() == 1) fall_after = n;
         if (pll_rst && !prev_pll) begin
            case (rises.size())
               1: chk("t4_retry_1", int'(retry_count), 1);
               2: chk("t4_retry_2", int'(retry_count), 2);
               default: chk("t4_retry_sat", int'(retry_count), 3);
            endcase
         end
         prev_pll = pll_rst;
      end
      chk("t4_rise_count", rises.size(), 4);
      if (rises.size() >= 2) begin
         chk("t4_first_rise", rises[0], 36);
         chk("t4_period", rises[1] - rises[0], 36);
         chk("t4_width", fall_after - rises[0], 4);
      end

      // Five losses in RUN with a saturating loss counter.
      loss_exp = '{1, 2, 3, 3, 3};
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         run_until_ready("t5", n_edges);
         for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0);
         chk($sformatf("t5_loss_%0d", i), int'(loss_count), loss_exp[i]);
      end

      // Soft reset from RUN keeps counters; async rst mid-STABILIZE clears at once.
      run_until_ready("t6", n_edges);
      step(1'b0, 1'b1, 1'b1);
      chk("t6_soft_pll_rst", int'(pll_rst), 1);
      chk("t6_soft_sys_rst", int'(sys_rst), 1);
      chk("t6_soft_loss_kept", int'(loss_count), 3);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
      @(negedge refclk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("t6_async_pll_rst", int'(pll_rst), 1);
      chk("t6_async_sys_rst", int'(sys_rst), 1);
      chk("t6_async_ready", int'(ready), 0);
      chk("t6_async_loss", int'(loss_count), 0);
      chk("t6_async_retry", int'(retry_count), 0);
      step(1'b1, 1'b1, 1'b0);

      // Randomized runs of locked with sporadic soft and hard resets.
      steps = 0;
      while (steps < 4000) begin
         len = $urandom_range(1, 40);
         lv = ($urandom_range(0, 9) < 7);
         for (int j = 0; j < len; j++) begin
            step(($urandom_range(0, 399) == 0), lv, ($urandom_range(0, 99) == 0));
            steps++;
         end
      end

      step(1'b0, 1'b1, 1'b0);
      @(posedge refclk);
      #2;
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
